reg_status_cdb: RTL and testbench
=================================

# reg_status_cdb

Common-data-bus (CDB) arbiter and register-status table for the Tomasulo core. The block arbitrates finished results from the functional units onto a single registered CDB. It tracks which reservation-station tag each architectural register waits on, and drives the register file's write port (Wt_addr/Wt_data/EN, written on negedge clk). It sits directly upstream of the register file and beside the issue stage.

## Interface
Parameters:
- NUM_FU, 4, number of result producers
- TAG_W, 3, reservation-station tag width
- DATA_W, 32, result width

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- issue_en  in  1  issue stage renames a destination this cycle
- issue_rd  in  5  destination register of issuing instruction
- issue_tag  in  TAG_W  tag of the reservation station receiving it
- qa_addr, qb_addr  in  5 each  source register lookups for issue
- qa_busy, qb_busy  out  1 each  source still waiting on a tag
- qa_tag, qb_tag  out  TAG_W each  tag the source waits on
- fu_valid  in  NUM_FU  FU i holds a finished result
- fu_tag  in  NUM_FU*TAG_W  packed tags, FU i at bits [i*TAG_W +: TAG_W]
- fu_data  in  NUM_FU*DATA_W  packed results
- fu_ready  out  NUM_FU  one-hot grant; transfer when fu_valid[i] & fu_ready[i]
- cdb_valid  out  1  broadcast valid (registered)
- cdb_tag  out  TAG_W  broadcast tag (registered)
- cdb_data  out  DATA_W  broadcast data (registered)
- wt_en  out  1  register-file write enable
- wt_addr  out  5  register-file write address
- wt_data  out  DATA_W  register-file write data

## Operation
- Status table: entries r1..r31, each holding {busy, tag}. r0 has no entry and always reads not busy with tag 0.
- Issue: when issue_en is high and issue_rd != 0, entry issue_rd ← {1, issue_tag} at posedge. When issue_rd == 0, the issue is ignored.
- Arbitration: round-robin over fu_valid, starting the search at pointer p. Exactly one fu_ready bit is high when any fu_valid is high; all bits are 0 otherwise. After a grant to FU i, p ← (i+1) mod NUM_FU. With no grant, p holds.
- The CDB has no backpressure. A granted result loads {cdb_valid=1, cdb_tag, cdb_data} at the next posedge. With no grant, cdb_valid ← 0 and tag/data hold.
- Writeback is combinational from the CDB register and the table:
  - wt_en = cdb_valid & (some entry r has busy=1 and tag == cdb_tag).
  - wt_addr = that r; wt_data = cdb_data.
  - At most one entry can match, because tags are unique among in-flight instructions.
  - With no match (WAW: rd already renamed by a younger instruction), wt_en=0 and wt_addr=0.
- On a match, that entry's busy ← 0 at the following posedge.
- Simultaneous issue and clear on the same entry: issue wins (entry ← {1, issue_tag}). wt_en still asserts for the old value.
- Lookup:
  - qX_busy = entry.busy & ~(cdb_valid & entry.tag == cdb_tag).
  - qX_tag = entry.tag.
  - This bypass is safe because the register file writes on the negedge inside the same cycle, so its read data is correct before the issue stage samples at the next posedge.
  - Lookup does not see a same-cycle issue to the same register; the issue stage handles intra-instruction dependencies.

## Timing
- Reset (async, rst_n=0) sets:
  - all busy=0, tags=0
  - cdb_valid=0, cdb_tag=0, cdb_data=0
  - p=0
  - fu_ready=0 while in reset
  - wt_en=0, wt_addr=0, wt_data=0 (derived)
- Reset asserted mid-broadcast drops cdb_valid immediately. A result in flight is lost, and the upstream pipeline is flushed by the same reset.
- Latency: handshake at posedge k → cdb_valid high from k to k+1 → register file written at the negedge in that interval → status busy cleared at k+1.
- Throughput: one result per cycle. A continuously valid FU receives at most one grant every NUM_FU cycles while all others are also valid.
- fu_ready is combinational from fu_valid and p. FUs must not make fu_valid depend on fu_ready.

## Structure
- Shared package tomasulo_pkg holds TAG_W, NUM_FU, DATA_W, the reg_idx_t (5-bit) typedef, and the status-entry struct {busy, tag}.
- One sub-module: rr_arbiter (NUM_FU-wide request, one-hot grant, pointer update on grant), reusable for the issue-port arbitration.
- The status table and CDB register live in the top module.

## Test plan
- Reset, then issue r5←tag 2; FU1 presents tag 2, data 0xDEADBEEF → cdb_valid next cycle, wt_en=1, wt_addr=5, wt_data=0xDEADBEEF; r5 busy=0 the cycle after.
- All four FUs valid, p=0 → grants in order FU0, FU1, FU2, FU3, FU0 on consecutive cycles; cdb_tag sequence follows.
- WAW: issue r7←tag 1, then r7←tag 4; broadcast tag 1 → wt_en=0 and r7 stays busy with tag 4; broadcast tag 4 → write r7.
- Bypass: r3 busy with tag 6 and cdb_tag=6 valid in the same cycle, qa_addr=3 → qa_busy=0 that cycle.
- Issue r9←tag 5 in the same cycle a broadcast clears r9 (old tag 3) → wt_en=1 for r9, and r9 ends busy with tag 5.
- Issue to r0, then lookup r0 → busy=0 and tag=0; rst_n pulsed low mid-broadcast → cdb_valid drops asynchronously and all entries read not busy.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: sizes, register index
// and the register-status entry.
package tomasulo_pkg;

  localparam int NUM_FU = 4;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } stat_t;

endpackage

// File: rtl/reg_status_cdb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search
// starts at ptr, ptr moves past each winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] j;
  logic          hit;
  int            sum;

  // first requester at or after ptr, wrapping
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    hit     = 1'b0;
    j       = '0;
    sum     = 0;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        sum = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        j = PW'(sum);
        if (!hit && req[j]) begin
          hit    = 1'b1;
          gnt[j] = 1'b1;
          if (j == PW'(N - 1))
            ptr_nxt = '0;
          else
            ptr_nxt = j + 1'b1;
        end
      end
    end
  end

  // pointer advances only on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (hit)
      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/reg_status_cdb.sv
// CDB arbiter, CDB register and register-status
// table driving the register-file write port.
module reg_status_cdb #(
  parameter int NUM_FU = tomasulo_pkg::NUM_FU,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int DATA_W = tomasulo_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_en,
  input  logic [4:0]               issue_rd,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic [4:0]               qa_addr,
  input  logic [4:0]               qb_addr,
  output logic                     qa_busy,
  output logic                     qb_busy,
  output logic [TAG_W-1:0]         qa_tag,
  output logic [TAG_W-1:0]         qb_tag,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic                     wt_en,
  output logic [4:0]               wt_addr,
  output logic [DATA_W-1:0]        wt_data
);

  import tomasulo_pkg::*;

  stat_t             tbl [1:31];
  logic [NUM_FU-1:0] gnt;
  logic              g_any;
  logic [TAG_W-1:0]  g_tag;
  logic [DATA_W-1:0] g_data;
  logic              hit;
  reg_idx_t          hit_r;
  stat_t             ea;
  stat_t             eb;

  rr_arbiter #(
    .N (NUM_FU)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (fu_valid),
    .gnt   (gnt)
  );

  assign fu_ready = gnt;

  // select the granted FU's tag and data
  always_comb begin
    g_any  = |gnt;
    g_tag  = '0;
    g_data = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i]) begin
        g_tag  = fu_tag[i*TAG_W +: TAG_W];
        g_data = fu_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // find the entry still waiting on the CDB tag
  always_comb begin
    hit   = 1'b0;
    hit_r = '0;
    for (int r = 1; r < 32; r++) begin
      if (cdb_valid && tbl[r].busy &&
          tbl[r].tag == cdb_tag) begin
        hit   = 1'b1;
        hit_r = reg_idx_t'(r);
      end
    end
  end

  assign wt_en   = hit;
  assign wt_addr = hit_r;
  assign wt_data = cdb_data;

  // source lookup with same-cycle CDB bypass
  always_comb begin
    ea = '0;
    eb = '0;
    if (qa_addr != '0) ea = tbl[qa_addr];
    if (qb_addr != '0) eb = tbl[qb_addr];
    qa_busy = ea.busy &
              ~(cdb_valid & (ea.tag == cdb_tag));
    qb_busy = eb.busy &
              ~(cdb_valid & (eb.tag == cdb_tag));
    qa_tag  = ea.tag;
    qb_tag  = eb.tag;
  end

  // rename on issue; clear on writeback; issue wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++)
        tbl[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue_en &&
            issue_rd == reg_idx_t'(r)) begin
          tbl[r].busy <= 1'b1;
          tbl[r].tag  <= issue_tag;
        end else if (hit &&
                     hit_r == reg_idx_t'(r)) begin
          tbl[r].busy <= 1'b0;
        end
      end
    end
  end

  // CDB register; tag/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      cdb_valid <= g_any;
      if (g_any) begin
        cdb_tag  <= g_tag;
        cdb_data <= g_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_status_cdb.sv
// Self-checking bench for reg_status_cdb:
// vector table, directed sequences, random vs model.
module tb_reg_status_cdb;

  localparam int NF = 4;
  localparam int TW = 3;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_en;
  logic [4:0]       issue_rd;
  logic [TW-1:0]    issue_tag;
  logic [4:0]       qa_addr, qb_addr;
  logic             qa_busy, qb_busy;
  logic [TW-1:0]    qa_tag, qb_tag;
  logic [NF-1:0]    fu_valid, fu_ready;
  logic [NF*TW-1:0] fu_tag;
  logic [NF*DW-1:0] fu_data;
  logic             cdb_valid;
  logic [TW-1:0]    cdb_tag;
  logic [DW-1:0]    cdb_data;
  logic             wt_en;
  logic [4:0]       wt_addr;
  logic [DW-1:0]    wt_data;

  reg_status_cdb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .issue_tag (issue_tag),
    .qa_addr   (qa_addr),
    .qb_addr   (qb_addr),
    .qa_busy   (qa_busy),
    .qb_busy   (qb_busy),
    .qa_tag    (qa_tag),
    .qb_tag    (qb_tag),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_data   (fu_data),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .wt_en     (wt_en),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: per-register waits, CDB, pointer
  bit          mb [32];
  int          mt [32];
  bit          mv;
  int          mtag;
  logic [31:0] mdata;
  int          mp;

  typedef struct {
    logic [3:0] v;
    logic [3:0] rdy;
    logic       cv;
    logic [2:0] ct;
  } arb_vec_t;

  arb_vec_t av [10];

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) begin
      mb[r] = 1'b0;
      mt[r] = 0;
    end
    mv    = 1'b0;
    mtag  = 0;
    mdata = '0;
    mp    = 0;
  endfunction

  function automatic int m_grant();
    for (int k = 0; k < NF; k++) begin
      int i;
      i = (mp + k) % NF;
      if (fu_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic int m_match();
    if (!mv) return 0;
    for (int r = 1; r < 32; r++)
      if (mb[r] && mt[r] == mtag) return r;
    return 0;
  endfunction

  function automatic bit m_qbusy(int a);
    if (a == 0) return 1'b0;
    return mb[a] && !(mv && mt[a] == mtag);
  endfunction

  function automatic int m_qtag(int a);
    if (a == 0) return 0;
    return mt[a];
  endfunction

  task automatic idle();
    issue_en  = 1'b0;
    issue_rd  = '0;
    issue_tag = '0;
    fu_valid  = '0;
    qa_addr   = '0;
    qb_addr   = '0;
  endtask

  task automatic set_fu(int i, int t,
                        logic [31:0] d);
    fu_tag[i*TW +: TW]  = TW'(t);
    fu_data[i*DW +: DW] = d;
  endtask

  // one clock: combinational checks, edge, then
  // model update and registered-output checks
  task automatic step();
    int         g, r;
    bit         ie;
    int         ird, itg;
    logic [3:0] er;
    #2;
    g   = m_grant();
    r   = m_match();
    ie  = issue_en;
    ird = int'(issue_rd);
    itg = int'(issue_tag);
    er  = (g < 0) ? 4'b0 : 4'(1 << g);
    chk("fu_ready", fu_ready, er);
    chk("wt_en", wt_en, r != 0);
    chk("wt_addr", wt_addr, r);
    chk("wt_data", wt_data, mdata);
    chk("qa_busy", qa_busy, m_qbusy(qa_addr));
    chk("qa_tag", qa_tag, m_qtag(qa_addr));
    chk("qb_busy", qb_busy, m_qbusy(qb_addr));
    chk("qb_tag", qb_tag, m_qtag(qb_addr));
    if (g >= 0) begin
      mtag  = int'(fu_tag[g*TW +: TW]);
      mdata = fu_data[g*DW +: DW];
    end
    @(posedge clk);
    #1;
    if (r != 0) mb[r] = 1'b0;
    if (ie && ird != 0) begin
      mb[ird] = 1'b1;
      mt[ird] = itg;
    end
    mv = (g >= 0);
    if (g >= 0) mp = (g + 1) % NF;
    chk("cdb_valid", cdb_valid, mv);
    chk("cdb_tag", cdb_tag, mtag);
    chk("cdb_data", cdb_data, mdata);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    #2;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_cycle();
    int st, ft;
    idle();
    fu_valid = 4'($urandom_range(0, 15));
    for (int i = 0; i < NF; i++)
      set_fu(i, $urandom_range(0, 7), $urandom);
    qa_addr = 5'($urandom_range(0, 31));
    qb_addr = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 1) == 1) begin
      st = $urandom_range(0, 7);
      ft = -1;
      for (int k = 0; k < 8; k++) begin
        int t;
        bit used;
        t = (st + k) % 8;
        used = 1'b0;
        for (int r = 1; r < 32; r++)
          if (mb[r] && mt[r] == t) used = 1'b1;
        if (!used && ft < 0) ft = t;
      end
      if (ft >= 0) begin
        issue_en  = 1'b1;
        issue_rd  = 5'($urandom_range(0, 31));
        issue_tag = TW'(ft);
      end
    end
    step();
  endtask

  initial begin
    fu_tag  = '0;
    fu_data = '0;
    idle();
    m_reset();

    // reset state, grants gated while in reset
    fu_valid = 4'b1111;
    #3;
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_fu_ready", fu_ready, 0);
    chk("rst_wt_en", wt_en, 0);
    chk("rst_wt_addr", wt_addr, 0);
    chk("rst_wt_data", wt_data, 0);
    do_reset();

    // basic writeback: r5 <- tag 2 via FU1
    issue_en = 1'b1; issue_rd = 5; issue_tag = 2;
    step();
    idle();
    fu_valid = 4'b0010;
    set_fu(1, 2, 32'hDEADBEEF);
    #1;
    chk("s1_ready", fu_ready, 4'b0010);
    step();
    chk("s1_cdb_valid", cdb_valid, 1);
    chk("s1_cdb_tag", cdb_tag, 2);
    idle();
    qa_addr = 5;
    #1;
    chk("s1_wt_en", wt_en, 1);
    chk("s1_wt_addr", wt_addr, 5);
    chk("s1_wt_data", wt_data, 32'hDEADBEEF);
    chk("s1_bypass", qa_busy, 0);
    step();
    #1;
    chk("s1_cleared", qa_busy, 0);
    chk("s1_no_wt", wt_en, 0);

    // WAW: r7 <- 1 then r7 <- 4
    issue_en = 1'b1; issue_rd = 7; issue_tag = 1;
    step();
    issue_tag = 4;
    step();
    idle();
    fu_valid = 4'b0001;
    set_fu(0, 1, 32'h111);
    step();
    idle();
    qa_addr = 7;
    #1;
    chk("waw_wt_en", wt_en, 0);
    chk("waw_wt_addr", wt_addr, 0);
    chk("waw_busy", qa_busy, 1);
    chk("waw_tag", qa_tag, 4);
    step();
    fu_valid = 4'b0100;
    set_fu(2, 4, 32'h444);
    step();
    idle();
    #1;
    chk("waw2_wt_en", wt_en, 1);
    chk("waw2_wt_addr", wt_addr, 7);
    chk("waw2_wt_data", wt_data, 32'h444);
    step();

    // bypass: r3 waits on tag 6 while CDB has 6
    issue_en = 1'b1; issue_rd = 3; issue_tag = 6;
    step();
    idle();
    qa_addr = 3;
    fu_valid = 4'b1000;
    set_fu(3, 6, 32'h666);
    #1;
    chk("byp_before", qa_busy, 1);
    step();
    idle();
    qa_addr = 3;
    qb_addr = 3;
    #1;
    chk("byp_qa_busy", qa_busy, 0);
    chk("byp_qb_busy", qb_busy, 0);
    chk("byp_qa_tag", qa_tag, 6);
    step();

    // issue and clear on r9 in the same cycle
    issue_en = 1'b1; issue_rd = 9; issue_tag = 3;
    step();
    idle();
    fu_valid = 4'b0001;
    set_fu(0, 3, 32'h999);
    step();
    idle();
    issue_en = 1'b1; issue_rd = 9; issue_tag = 5;
    #1;
    chk("ic_wt_en", wt_en, 1);
    chk("ic_wt_addr", wt_addr, 9);
    step();
    idle();
    qa_addr = 9;
    #1;
    chk("ic_busy", qa_busy, 1);
    chk("ic_tag", qa_tag, 5);
    step();

    // r0 never renames
    issue_en = 1'b1; issue_rd = 0; issue_tag = 7;
    step();
    idle();
    #1;
    chk("r0_busy", qa_busy, 0);
    chk("r0_tag", qa_tag, 0);
    step();

    // async reset mid-broadcast
    issue_en = 1'b1; issue_rd = 10; issue_tag = 7;
    step();
    idle();
    fu_valid = 4'b0010;
    set_fu(1, 7, 32'hA5A5);
    step();
    fu_valid = 4'b1111;
    qa_addr = 10;
    qb_addr = 5'd9;
    #1;
    chk("mr_pre_valid", cdb_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_cdb_valid", cdb_valid, 0);
    chk("mr_fu_ready", fu_ready, 0);
    chk("mr_wt_en", wt_en, 0);
    chk("mr_qa_busy", qa_busy, 0);
    chk("mr_qb_busy", qb_busy, 0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    step();

    // round-robin vectors from a fresh pointer
    do_reset();
    for (int i = 0; i < NF; i++)
      set_fu(i, i, 32'h11111111 * i);
    av[0] = '{4'b1111, 4'b0001, 1'b1, 3'd0};
    av[1] = '{4'b1111, 4'b0010, 1'b1, 3'd1};
    av[2] = '{4'b1111, 4'b0100, 1'b1, 3'd2};
    av[3] = '{4'b1111, 4'b1000, 1'b1, 3'd3};
    av[4] = '{4'b1111, 4'b0001, 1'b1, 3'd0};
    av[5] = '{4'b0000, 4'b0000, 1'b0, 3'd0};
    av[6] = '{4'b0001, 4'b0001, 1'b1, 3'd0};
    av[7] = '{4'b1001, 4'b1000, 1'b1, 3'd3};
    av[8] = '{4'b0110, 4'b0010, 1'b1, 3'd1};
    av[9] = '{4'b0110, 4'b0100, 1'b1, 3'd2};
    for (int k = 0; k < 10; k++) begin
      fu_valid = av[k].v;
      #1;
      chk($sformatf("arb%0d_ready", k),
          fu_ready, av[k].rdy);
      step();
      chk($sformatf("arb%0d_cv", k),
          cdb_valid, av[k].cv);
      chk($sformatf("arb%0d_ct", k),
          cdb_tag, av[k].ct);
    end
    idle();
    step();

    // random traffic against the model
    for (int n = 0; n < 600; n++)
      rand_cycle();
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
